// File: rtl/id_hazard_redirect_pkg.sv
// Shared definitions for the ID-stage hazard/redirect unit: opcodes, FSM
// states and default widths.
package id_hazard_redirect_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned REGADDR_W_DEF = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        RWAIT = 2'd2
    } state_e;

endpackage

// File: rtl/id_branch_resolve.sv
// Combinational branch/jump resolution: decides whether the control transfer
// in ID is taken and computes its target.
module id_branch_resolve
    import id_hazard_redirect_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            is_branch,
    output logic            is_jump,
    output logic            taken,
    output logic [XLEN-1:0] target
);

    logic [5:0]      op;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jmp_target;

    // Decode, compare operands and form both candidate targets.
    always_comb begin
        op         = instr[31:26];
        imm_ext    = {{(XLEN-16){instr[15]}}, instr[15:0]};
        br_target  = pc_plus4 + (imm_ext << 2);
        // Jumps keep the upper PC bits and replace the low 28.
        jmp_target        = pc_plus4;
        jmp_target[27:0]  = {instr[25:0], 2'b00};

        is_branch = (op == OP_BEQ) || (op == OP_BNE);
        is_jump   = (op == OP_J) || (op == OP_JAL);
        taken     = is_jump
                  || ((op == OP_BEQ) && (rs_data == rt_data))
                  || ((op == OP_BNE) && (rs_data != rt_data));
        target    = is_branch ? br_target : jmp_target;
    end

endmodule

// File: rtl/id_hazard_redirect.sv
// ID-stage hazard detection and PC redirect control.
// Optional performance counters are enabled by defining ID_HAZARD_PERF_CNT_EN.
module id_hazard_redirect
    import id_hazard_redirect_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned REGADDR_W = REGADDR_W_DEF,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      instructionReg,
    input  logic [XLEN-1:0]      PCReg,
    input  logic [XLEN-1:0]      rs_data,
    input  logic [XLEN-1:0]      rt_data,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_read,
    input  logic [REGADDR_W-1:0] ex_rd,
    input  logic                 mem_mem_read,
    input  logic [REGADDR_W-1:0] mem_rd,
    input  logic                 redirect_ready,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 id_bubble,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] latch_q, latch_d;

    logic [5:0]           op;
    logic [REGADDR_W-1:0] rs_idx;
    logic [REGADDR_W-1:0] rt_idx;
    logic                 rt_used;
    logic                 load_use;
    logic                 branch_hz;
    logic                 hazard;

    logic            is_branch;
    logic            is_jump;
    logic            br_taken;
    logic [XLEN-1:0] br_target;

    id_branch_resolve #(
        .XLEN (XLEN)
    ) u_resolve (
        .instr     (instructionReg),
        .pc_plus4  (PCReg),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .taken     (br_taken),
        .target    (br_target)
    );

    // Source-operand hazard detection; register 0 never matches.
    always_comb begin
        op      = instructionReg[31:26];
        rs_idx  = instructionReg[21 +: REGADDR_W];
        rt_idx  = instructionReg[16 +: REGADDR_W];
        rt_used = (op == OP_RTYPE) || is_branch || (op == OP_SW);

        load_use = ex_mem_read && (ex_rd != '0)
                 && ((ex_rd == rs_idx) || (rt_used && (ex_rd == rt_idx)));

        // Branches compare in ID, so any in-flight producer blocks them.
        branch_hz = is_branch && (
                      (ex_reg_write && (ex_rd != '0)
                          && ((ex_rd == rs_idx) || (ex_rd == rt_idx)))
                   || (mem_mem_read && (mem_rd != '0)
                          && ((mem_rd == rs_idx) || (mem_rd == rt_idx))));

        hazard = load_use || branch_hz;
    end

    // FSM next state and combinational control outputs.
    always_comb begin
        state_d        = state_q;
        latch_d        = latch_q;
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        id_bubble      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        if (!reset) begin
            id_bubble = 1'b1;
            state_d   = RUN;
            latch_d   = '0;
        end else begin
            unique case (state_q)
                RUN, STALL: begin
                    if (hazard) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        id_bubble  = 1'b1;
                        state_d    = STALL;
                    end else if (br_taken) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = br_target;
                        pc_write       = 1'b0;
                        ifid_write     = 1'b0;
                        if (redirect_ready) begin
                            ifid_flush = 1'b1;
                            state_d    = RUN;
                        end else begin
                            id_bubble = 1'b1;
                            latch_d   = br_target;
                            state_d   = RWAIT;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                RWAIT: begin
                    // Target comes from the latch so it holds while IF/ID changes.
                    redirect_valid = 1'b1;
                    redirect_pc    = latch_q;
                    pc_write       = 1'b0;
                    ifid_write     = 1'b0;
                    if (redirect_ready) begin
                        ifid_flush = 1'b1;
                        state_d    = RUN;
                    end else begin
                        id_bubble = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State and redirect-target latch registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
        end
    end

`ifdef ID_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters for bubbles and accepted redirects.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (id_bubble && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_valid && redirect_ready && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers; cleared in reset so reset cycles never count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
